// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES engine controller: data width, controller states and job mode.
// Imported by the timer and the controller top.
package aes_ctrl_pkg;

    localparam int AES_W = 128;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        KEXP = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        RESP = 3'd4
    } ctrl_state_t;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } aes_mode_t;

endpackage

// File: rtl/aes_ctrl_timer.sv
// Timing helpers for the AES controller: inverse-key-expansion down-counter and
// a saturating 10-bit watchdog, each exposing a terminal flag.
module aes_ctrl_timer
    import aes_ctrl_pkg::*;
#(
    parameter int KEXP_CYCLES    = 12,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic kexp_load,
    input  logic kexp_dec,
    input  logic wd_clear,
    input  logic wd_inc,
    output logic kexp_zero,
    output logic wd_expired
);

    localparam logic [7:0] KEXP_INIT = 8'(KEXP_CYCLES);
    localparam logic [9:0] WD_LIMIT  = 10'(TIMEOUT_CYCLES);
    localparam logic [9:0] WD_MAX    = 10'h3FF;

    logic [7:0] kexp_cnt_r;
    logic [9:0] wd_cnt_r;

    // Key-expansion wait counter: loaded on the key-load strobe, counts down to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            kexp_cnt_r <= 8'd0;
        end else if (kexp_load) begin
            kexp_cnt_r <= KEXP_INIT;
        end else if (kexp_dec && (kexp_cnt_r != 8'd0)) begin
            kexp_cnt_r <= kexp_cnt_r - 8'd1;
        end else begin
            kexp_cnt_r <= kexp_cnt_r;
        end
    end

    // Watchdog: cleared when a job is launched, then counts run cycles and saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_r <= 10'd0;
        end else if (wd_clear) begin
            wd_cnt_r <= 10'd0;
        end else if (wd_inc && (wd_cnt_r != WD_MAX)) begin
            wd_cnt_r <= wd_cnt_r + 10'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    assign kexp_zero  = (kexp_cnt_r == 8'd0);
    assign wd_expired = (wd_cnt_r == WD_LIMIT);

endmodule

// File: rtl/aes_engine_ctrl.sv
// Single-job scheduler for the AES encrypt/decrypt cores: sequences ld/kld strobes,
// caches the last expanded decrypt key and aborts hung jobs via a watchdog.
module aes_engine_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int KEXP_CYCLES    = 12,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_mode,
    input  logic [AES_W-1:0] req_key,
    input  logic [AES_W-1:0] req_text,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [AES_W-1:0] rsp_text,
    output logic             rsp_mode,
    output logic             rsp_err,
    output logic [AES_W-1:0] eng_key,
    output logic [AES_W-1:0] eng_text,
    output logic             enc_ld,
    output logic             dec_kld,
    output logic             dec_ld,
    input  logic             enc_done,
    input  logic [AES_W-1:0] enc_text,
    input  logic             dec_done,
    input  logic [AES_W-1:0] dec_text
);

    localparam logic [2:0] ST_IDLE = 3'(IDLE);
    localparam logic [2:0] ST_KEXP = 3'(KEXP);
    localparam logic [2:0] ST_LOAD = 3'(LOAD);
    localparam logic [2:0] ST_RUN  = 3'(RUN);
    localparam logic [2:0] ST_RESP = 3'(RESP);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    aes_mode_t        mode_r;
    aes_mode_t        mode_nxt_s;
    logic             req_ready_r;
    logic             enc_ld_r;
    logic             dec_kld_r;
    logic             dec_ld_r;
    logic [AES_W-1:0] eng_key_r;
    logic [AES_W-1:0] eng_text_r;
    logic             cache_vld_r;
    logic [AES_W-1:0] cache_key_r;
    logic             rsp_valid_r;
    logic [AES_W-1:0] rsp_text_r;
    logic             rsp_mode_r;
    logic             rsp_err_r;

    logic             accept_s;
    logic             hit_s;
    logic             kld_s;
    logic             done_s;
    logic [AES_W-1:0] core_text_s;
    logic             finish_s;
    logic             timeout_s;
    logic             kexp_zero_s;
    logic             wd_expired_s;

    aes_ctrl_timer #(
        .KEXP_CYCLES    (KEXP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .kexp_load  (kld_s),
        .kexp_dec   (state_r == ST_KEXP),
        .wd_clear   (state_r == ST_LOAD),
        .wd_inc     (state_r == ST_RUN),
        .kexp_zero  (kexp_zero_s),
        .wd_expired (wd_expired_s)
    );

    // Request decode, core selection and next-state logic.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && req_valid && req_ready_r;
        hit_s       = cache_vld_r && (req_key == cache_key_r);
        kld_s       = accept_s && (aes_mode_t'(req_mode) == MODE_DEC) && !hit_s;
        mode_nxt_s  = accept_s ? aes_mode_t'(req_mode) : mode_r;
        // Only the core that owns the current job may complete it.
        done_s      = (mode_r == MODE_DEC) ? dec_done : enc_done;
        core_text_s = (mode_r == MODE_DEC) ? dec_text : enc_text;
        finish_s    = (state_r == ST_RUN) && done_s;
        timeout_s   = (state_r == ST_RUN) && !done_s && wd_expired_s;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = kld_s ? ST_KEXP : ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_KEXP: begin
                if (kexp_zero_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_KEXP;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (finish_s || timeout_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state and registered strobes; ld fires in the single LOAD cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= MODE_ENC;
            req_ready_r <= 1'b1;
            enc_ld_r    <= 1'b0;
            dec_kld_r   <= 1'b0;
            dec_ld_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mode_r      <= mode_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            enc_ld_r    <= (state_nxt_s == ST_LOAD) && (mode_nxt_s == MODE_ENC);
            dec_ld_r    <= (state_nxt_s == ST_LOAD) && (mode_nxt_s == MODE_DEC);
            dec_kld_r   <= kld_s;
        end
    end

    // Operand registers and decrypt key cache; a hung decrypt invalidates the cache.
    always_ff @(posedge clk) begin
        if (!rst) begin
            eng_key_r   <= {AES_W{1'b0}};
            eng_text_r  <= {AES_W{1'b0}};
            cache_vld_r <= 1'b0;
            cache_key_r <= {AES_W{1'b0}};
        end else begin
            if (accept_s) begin
                eng_key_r  <= req_key;
                eng_text_r <= req_text;
            end else begin
                eng_key_r  <= eng_key_r;
                eng_text_r <= eng_text_r;
            end
            if (kld_s) begin
                cache_vld_r <= 1'b1;
                cache_key_r <= req_key;
            end else if (timeout_s && (mode_r == MODE_DEC)) begin
                cache_vld_r <= 1'b0;
                cache_key_r <= cache_key_r;
            end else begin
                cache_vld_r <= cache_vld_r;
                cache_key_r <= cache_key_r;
            end
        end
    end

    // Response register: filled on completion or timeout, held until consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_r <= 1'b0;
            rsp_text_r  <= {AES_W{1'b0}};
            rsp_mode_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else if (finish_s) begin
            rsp_valid_r <= 1'b1;
            rsp_text_r  <= core_text_s;
            rsp_mode_r  <= mode_r;
            rsp_err_r   <= 1'b0;
        end else if (timeout_s) begin
            rsp_valid_r <= 1'b1;
            rsp_text_r  <= {AES_W{1'b0}};
            rsp_mode_r  <= mode_r;
            rsp_err_r   <= 1'b1;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_text_r  <= rsp_text_r;
            rsp_mode_r  <= rsp_mode_r;
            rsp_err_r   <= rsp_err_r;
        end else begin
            rsp_valid_r <= rsp_valid_r;
            rsp_text_r  <= rsp_text_r;
            rsp_mode_r  <= rsp_mode_r;
            rsp_err_r   <= rsp_err_r;
        end
    end

    assign req_ready = req_ready_r;
    assign enc_ld    = enc_ld_r;
    assign dec_kld   = dec_kld_r;
    assign dec_ld    = dec_ld_r;
    assign eng_key   = eng_key_r;
    assign eng_text  = eng_text_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_text  = rsp_text_r;
    assign rsp_mode  = rsp_mode_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_aes_engine_ctrl.sv
// Self-checking bench for aes_engine_ctrl: the bench plays both AES cores and
// predicts strobe timing, cache hits and responses from a job-level model.
module tb_aes_engine_ctrl;

    localparam int KEXP = 12;
    localparam int TMO  = 63;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_mode = 1'b0;
    logic [127:0] req_key = 128'd0;
    logic [127:0] req_text = 128'd0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_text;
    logic         rsp_mode;
    logic         rsp_err;
    logic [127:0] eng_key;
    logic [127:0] eng_text;
    logic         enc_ld;
    logic         dec_kld;
    logic         dec_ld;
    logic         enc_done = 1'b0;
    logic [127:0] enc_text = 128'd0;
    logic         dec_done = 1'b0;
    logic [127:0] dec_text = 128'd0;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_enc = 0;
    int n_kld = 0;
    int n_dld = 0;
    int n_overlap = 0;
    int ld_cyc = -1;

    // Job-level model of the decrypt key cache
    logic         m_vld = 1'b0;
    logic [127:0] m_key = 128'd0;

    always #5 clk = ~clk;

    aes_engine_ctrl #(.KEXP_CYCLES(KEXP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_text(req_text),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text),
        .rsp_mode(rsp_mode), .rsp_err(rsp_err),
        .eng_key(eng_key), .eng_text(eng_text),
        .enc_ld(enc_ld), .dec_kld(dec_kld), .dec_ld(dec_ld),
        .enc_done(enc_done), .enc_text(enc_text),
        .dec_done(dec_done), .dec_text(dec_text)
    );

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (enc_ld)  n_enc++;
        if (dec_kld) n_kld++;
        if (dec_ld)  n_dld++;
        if ((int'(enc_ld) + int'(dec_kld) + int'(dec_ld)) > 1) n_overlap++;
        if (enc_ld || dec_ld) ld_cyc = cyc;
    endtask

    // lat: edges after the ld edge at which done is presented (-1 = never)
    task automatic do_job(input logic mode, input logic [127:0] key, input logic [127:0] text,
                          input int lat, input logic stray, input int hold,
                          input logic [127:0] core_out);
        logic         exp_kld;
        logic         timed_out;
        logic [127:0] exp_text;
        logic         early;
        logic         stable;
        logic [129:0] snap;
        int           t_acc;
        int           v_edge;
        int           nxt;
        int           kld0;
        int           enc0;
        int           dld0;
        int           w;

        exp_kld = mode && !(m_vld && (key == m_key));
        if (exp_kld) begin
            m_vld = 1'b1;
            m_key = key;
        end
        w = 0;
        while (!req_ready && (w < 20)) begin
            tick();
            w++;
        end
        check("req_ready_idle", req_ready, 1);

        kld0 = n_kld; enc0 = n_enc; dld0 = n_dld;
        ld_cyc = -1;
        req_valid = 1'b1; req_mode = mode; req_key = key; req_text = text;
        tick();
        t_acc = cyc;
        req_valid = 1'b0; req_key = rnd128(); req_text = rnd128();
        check("req_ready_busy", req_ready, 0);
        check("eng_key", eng_key, key);
        check("eng_text", eng_text, text);

        w = 0;
        while ((ld_cyc < 0) && (w < KEXP + 5)) begin
            tick();
            w++;
        end
        check("ld_offset", ld_cyc - t_acc, exp_kld ? KEXP + 1 : 0);
        check("kld_count", n_kld - kld0, exp_kld);
        check("enc_ld_count", n_enc - enc0, mode ? 0 : 1);
        check("dec_ld_count", n_dld - dld0, mode ? 1 : 0);
        if (ld_cyc < 0) ld_cyc = cyc;

        timed_out = (lat < 0) || (lat > TMO + 2);
        v_edge    = ld_cyc + (timed_out ? TMO + 2 : lat);
        exp_text  = timed_out ? 128'd0 : core_out;
        early     = 1'b0;
        while (cyc < v_edge) begin
            nxt      = cyc + 1 - ld_cyc;
            enc_done = (!mode && (nxt == lat)) || (mode && stray && (nxt == 3));
            dec_done = (mode && (nxt == lat)) || (!mode && stray && (nxt == 3));
            enc_text = (!mode && (nxt == lat)) ? core_out : rnd128();
            dec_text = (mode && (nxt == lat)) ? core_out : rnd128();
            tick();
            if ((cyc < v_edge) && rsp_valid) early = 1'b1;
        end
        enc_done = 1'b0; dec_done = 1'b0;
        check("early_rsp", early, 0);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, timed_out);
        check("rsp_text", rsp_text, exp_text);
        check("rsp_mode", rsp_mode, mode);

        // Hold off the consumer while both cores keep signalling done
        snap = {rsp_text, rsp_err, rsp_mode};
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            enc_done = 1'b1; dec_done = 1'b1;
            enc_text = rnd128(); dec_text = rnd128();
            tick();
            if (!rsp_valid || req_ready || ({rsp_text, rsp_err, rsp_mode} != snap)) stable = 1'b0;
        end
        enc_done = 1'b0; dec_done = 1'b0;
        check("rsp_stable", stable, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_released", rsp_valid, 0);
        check("req_ready_after", req_ready, 1);
        check("strobe_overlap", n_overlap, 0);
        if (timed_out && mode) m_vld = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL sim_limit: time budget exhausted");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [127:0] k1;
        logic [127:0] k2;
        logic [127:0] k3;
        logic [127:0] keys [3];
        int           kc0;
        int           ld0;
        logic         quiet;
        int           r;
        int           lat;

        k1 = rnd128(); k2 = rnd128(); k3 = rnd128();
        keys[0] = k1; keys[1] = k2; keys[2] = rnd128();

        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_strobes", {enc_ld, dec_kld, dec_ld}, 0);
        check("reset_eng_key", eng_key, 0);
        check("reset_rsp_text", rsp_text, 0);

        // FIPS-197 vector through the encrypt path
        do_job(1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
               12, 1'b0, 0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        // Decrypt miss, hit, then a new key
        do_job(1'b1, k1, rnd128(), 10, 1'b0, 1, rnd128());
        do_job(1'b1, k1, rnd128(), 6, 1'b0, 0, rnd128());
        do_job(1'b1, k2, rnd128(), 9, 1'b0, 2, rnd128());
        // Stray decrypt-core done during an encrypt
        do_job(1'b0, k1, rnd128(), 8, 1'b1, 0, rnd128());
        // Hung decrypt, then the same key must be re-expanded
        do_job(1'b1, k2, rnd128(), -1, 1'b0, 0, rnd128());
        do_job(1'b1, k2, rnd128(), 5, 1'b0, 0, rnd128());
        // Done on the expiry cycle, consumer stalls 5 cycles
        do_job(1'b0, k3, rnd128(), TMO + 2, 1'b0, 5, rnd128());
        do_job(1'b1, k2, rnd128(), TMO + 1, 1'b0, 0, rnd128());

        // Reset while waiting on key expansion
        req_valid = 1'b1; req_mode = 1'b1; req_key = k3; req_text = rnd128();
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_strobes", {enc_ld, dec_kld, dec_ld}, 0);
        check("midrst_rsp", {rsp_valid, rsp_err, rsp_mode}, 0);
        check("midrst_eng", {eng_key, eng_text} != 256'd0, 0);
        check("midrst_req_ready", req_ready, 1);
        m_vld = 1'b0;
        kc0 = n_kld; ld0 = n_enc + n_dld;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) quiet = 1'b0;
        end
        check("midrst_quiet", {quiet, 32'(n_kld - kc0), 32'(n_enc + n_dld - ld0)}, {1'b1, 64'd0});
        do_job(1'b1, k2, rnd128(), 7, 1'b0, 0, rnd128());

        // Randomised job mix over a small key pool
        for (int j = 0; j < 25; j++) begin
            r = $urandom_range(0, 9);
            lat = (r == 0) ? -1 : (r == 1) ? TMO + 2 : $urandom_range(4, 20);
            do_job(1'($urandom_range(0, 1)), keys[$urandom_range(0, 2)], rnd128(), lat,
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), rnd128());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
